// File: rtl/ga_bus_pkg.sv
// rtl/ga_bus_pkg.sv - shared state encoding, limits and sizing helper for the bus drive arbiter
package ga_bus_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_OWN  = 2'd1;
  localparam state_t ST_GAP  = 2'd2;

  localparam int NREQ_MAX = 8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - round-robin winner search starting after the last owner, wrapping modulo NREQ
module rr_pick
  import ga_bus_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int SELW = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [SELW-1:0] last,
  output logic [SELW-1:0] winner,
  output logic            any
);

  int idx;

  // Scan from lowest priority down so the last hit is the closest requester after 'last'.
  always_comb begin
    winner = '0;
    idx    = 0;
    for (int i = NREQ; i >= 1; i--) begin
      idx = (int'(last) + i) % NREQ;
      if (req[idx]) winner = SELW'(idx);
    end
  end

  assign any = |req;

endmodule

// File: rtl/bus_drive_arbiter.sv
// rtl/bus_drive_arbiter.sv - round-robin owner of a shared tristate bus with break-before-make gap
module bus_drive_arbiter
  import ga_bus_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int TURN_CYC = 1,
  parameter int MAX_HOLD = 8,
  parameter int SELW     = clog2(NREQ)
) (
  input  logic            CLK16,
  input  logic            nRESET,
  input  logic [NREQ-1:0] REQ,
  output logic [NREQ-1:0] GRANT,
  output logic [NREQ-1:0] T_OUT,
  output logic [SELW-1:0] SEL,
  output logic            BUSY,
  output logic            TURN
);

  state_t          state, state_nxt;
  logic [7:0]      hold_cnt, hold_nxt;
  logic [3:0]      gap_cnt, gap_nxt;
  logic [SELW-1:0] last, last_nxt;
  logic [SELW-1:0] winner;
  logic            any_req;
  logic            owner_req, other_req, hold_full, gap_done, release_own;
  logic [NREQ-1:0] grant_nxt;
  logic [SELW-1:0] sel_nxt;
  logic            busy_nxt, turn_nxt;

  rr_pick #(.NREQ(NREQ), .SELW(SELW)) u_rr_pick (
    .req    (REQ),
    .last   (last),
    .winner (winner),
    .any    (any_req)
  );

  assign owner_req   = |(REQ & GRANT);
  assign other_req   = |(REQ & ~GRANT);
  assign hold_full   = (hold_cnt == 8'(MAX_HOLD));
  assign gap_done    = (gap_cnt == 4'(TURN_CYC));
  assign release_own = !owner_req || (hold_full && other_req);

  // Reset drops every driver at once, so no turnaround gap is needed after it.
  always_ff @(posedge CLK16) begin
    if (!nRESET) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
      gap_cnt  <= '0;
      last     <= SELW'(NREQ - 1);
      GRANT    <= '0;
      T_OUT    <= '1;
      SEL      <= '0;
      BUSY     <= 1'b0;
      TURN     <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
      gap_cnt  <= gap_nxt;
      last     <= last_nxt;
      GRANT    <= grant_nxt;
      T_OUT    <= ~grant_nxt;
      SEL      <= sel_nxt;
      BUSY     <= busy_nxt;
      TURN     <= turn_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    gap_nxt   = gap_cnt;
    last_nxt  = last;
    case (state)
      ST_IDLE: begin
        if (any_req) begin
          state_nxt = ST_OWN;
          hold_nxt  = 8'd1;
          last_nxt  = winner;
        end
      end
      ST_OWN: begin
        if (release_own) begin
          state_nxt = ST_GAP;
          gap_nxt   = 4'd1;
        end else if (!hold_full) begin
          hold_nxt = hold_cnt + 8'd1;
        end
      end
      ST_GAP: begin
        if (gap_done) state_nxt = ST_IDLE;
        else          gap_nxt   = gap_cnt + 4'd1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // SEL is only rewritten on a grant so the data mux keeps pointing at the last owner.
  always_comb begin
    grant_nxt = GRANT;
    sel_nxt   = SEL;
    busy_nxt  = BUSY;
    turn_nxt  = TURN;
    case (state)
      ST_IDLE: begin
        if (any_req) begin
          grant_nxt = NREQ'(1) << winner;
          sel_nxt   = winner;
          busy_nxt  = 1'b1;
          turn_nxt  = 1'b0;
        end
      end
      ST_OWN: begin
        if (release_own) begin
          grant_nxt = '0;
          busy_nxt  = 1'b0;
          turn_nxt  = 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_done) turn_nxt = 1'b0;
      end
      default: begin
        grant_nxt = '0;
        busy_nxt  = 1'b0;
        turn_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_bus_drive_arbiter.sv
// tb/tb_bus_drive_arbiter.sv - self-checking bench for bus_drive_arbiter
module tb_bus_drive_arbiter;

  typedef struct packed {
    logic [3:0] grant;
    logic [3:0] t_out;
    logic [1:0] sel;
    logic       busy;
    logic       turn;
  } exp_t;

  typedef struct {
    logic [3:0] req;
    exp_t       e;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       nreset;
  logic [3:0] req_a, req_b;
  logic [2:0] req_c;
  logic [3:0] g_a, t_a, g_b, t_b;
  logic [2:0] g_c, t_c;
  logic [1:0] sel_a, sel_b, sel_c;
  logic       busy_a, turn_a, busy_b, turn_b, busy_c, turn_c;

  int   n_asrt = 0;
  int   n_fail = 0;
  exp_t sb[$];
  vec_t vecs[18];

  bus_drive_arbiter #(.NREQ(4), .TURN_CYC(1), .MAX_HOLD(8), .SELW(2)) u_dut (
    .CLK16(clk), .nRESET(nreset), .REQ(req_a), .GRANT(g_a), .T_OUT(t_a),
    .SEL(sel_a), .BUSY(busy_a), .TURN(turn_a)
  );

  bus_drive_arbiter #(.NREQ(4), .TURN_CYC(3), .MAX_HOLD(8), .SELW(2)) u_dut_t3 (
    .CLK16(clk), .nRESET(nreset), .REQ(req_b), .GRANT(g_b), .T_OUT(t_b),
    .SEL(sel_b), .BUSY(busy_b), .TURN(turn_b)
  );

  bus_drive_arbiter #(.NREQ(3), .TURN_CYC(1), .MAX_HOLD(8), .SELW(2)) u_dut_n3 (
    .CLK16(clk), .nRESET(nreset), .REQ(req_c), .GRANT(g_c), .T_OUT(t_c),
    .SEL(sel_c), .BUSY(busy_c), .TURN(turn_c)
  );

  function automatic exp_t mk(input logic [3:0] g, input int sel, input logic busy, input logic turn);
    exp_t r;
    r.grant = g;
    r.t_out = ~g;
    r.sel   = 2'(sel);
    r.busy  = busy;
    r.turn  = turn;
    return r;
  endfunction

  function automatic exp_t sample(input int dut);
    exp_t r;
    case (dut)
      0:       r = {g_a, t_a, sel_a, busy_a, turn_a};
      1:       r = {g_b, t_b, sel_b, busy_b, turn_b};
      default: r = {{1'b0, g_c}, {1'b1, t_c}, sel_c, busy_c, turn_c};
    endcase
    return r;
  endfunction

  task automatic step(input int dut, input logic rst_n, input logic [3:0] req, input exp_t e, input string nm);
    exp_t got, want;
    nreset = rst_n;
    req_a  = (dut == 0) ? req : 4'b0000;
    req_b  = (dut == 1) ? req : 4'b0000;
    req_c  = (dut == 2) ? req[2:0] : 3'b000;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got  = sample(dut);
    want = sb.pop_front();
    n_asrt++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got grant=%b t_out=%b sel=%0d busy=%b turn=%b, expected grant=%b t_out=%b sel=%0d busy=%b turn=%b",
               nm, got.grant, got.t_out, got.sel, got.busy, got.turn,
               want.grant, want.t_out, want.sel, want.busy, want.turn);
    end
    n_asrt++;
    if ($countones(~got.t_out) > 1 || (got.busy && got.turn)) begin
      n_fail++;
      $display("FAIL %s_invariant: got t_out=%b busy=%b turn=%b, required at most one low enable and not both busy and turn",
               nm, got.t_out, got.busy, got.turn);
    end
  endtask

  initial begin
    logic [3:0] g;
    int         pos, own;
    exp_t       rst_e;

    rst_e = mk(4'b0000, 0, 1'b0, 1'b0);
    vecs[0]  = '{4'b0001, mk(4'b0001, 0, 1'b1, 1'b0)};
    vecs[1]  = '{4'b0001, mk(4'b0001, 0, 1'b1, 1'b0)};
    vecs[2]  = '{4'b0000, mk(4'b0000, 0, 1'b0, 1'b1)};
    vecs[3]  = '{4'b0000, mk(4'b0000, 0, 1'b0, 1'b0)};
    vecs[4]  = '{4'b0000, mk(4'b0000, 0, 1'b0, 1'b0)};
    vecs[5]  = '{4'b0100, mk(4'b0100, 2, 1'b1, 1'b0)};
    vecs[6]  = '{4'b1000, mk(4'b0000, 2, 1'b0, 1'b1)};
    vecs[7]  = '{4'b1000, mk(4'b0000, 2, 1'b0, 1'b0)};
    vecs[8]  = '{4'b1010, mk(4'b1000, 3, 1'b1, 1'b0)};
    vecs[9]  = '{4'b1010, mk(4'b1000, 3, 1'b1, 1'b0)};
    vecs[10] = '{4'b0010, mk(4'b0000, 3, 1'b0, 1'b1)};
    vecs[11] = '{4'b0010, mk(4'b0000, 3, 1'b0, 1'b0)};
    vecs[12] = '{4'b0010, mk(4'b0010, 1, 1'b1, 1'b0)};
    vecs[13] = '{4'b0000, mk(4'b0000, 1, 1'b0, 1'b1)};
    vecs[14] = '{4'b0001, mk(4'b0000, 1, 1'b0, 1'b0)};
    vecs[15] = '{4'b0001, mk(4'b0001, 0, 1'b1, 1'b0)};
    vecs[16] = '{4'b0000, mk(4'b0000, 0, 1'b0, 1'b1)};
    vecs[17] = '{4'b0000, mk(4'b0000, 0, 1'b0, 1'b0)};

    nreset = 1'b0;
    req_a  = 4'b0000;
    req_b  = 4'b0000;
    req_c  = 3'b000;

    step(0, 1'b0, 4'b0000, rst_e, "reset_dut");
    step(1, 1'b0, 4'b0000, rst_e, "reset_t3");
    step(2, 1'b0, 4'b0000, rst_e, "reset_n3");

    for (int i = 0; i < 18; i++)
      step(0, 1'b1, vecs[i].req, vecs[i].e, $sformatf("vec%0d", i));

    // Reset while requester 2 owns the bus, then priority restarts at requester 0.
    step(0, 1'b0, 4'b0000, rst_e, "rst_pre_own");
    step(0, 1'b1, 4'b0100, mk(4'b0100, 2, 1'b1, 1'b0), "own2");
    step(0, 1'b1, 4'b0100, mk(4'b0100, 2, 1'b1, 1'b0), "own2_hold");
    step(0, 1'b0, 4'b0100, rst_e, "rst_mid_own");
    step(0, 1'b1, 4'b0101, mk(4'b0001, 0, 1'b1, 1'b0), "post_rst_grant0");
    step(0, 1'b1, 4'b0101, mk(4'b0001, 0, 1'b1, 1'b0), "post_rst_hold0");

    // All four requesting: 8 owned cycles, one TURN cycle, one IDLE cycle per owner.
    step(0, 1'b0, 4'b0000, rst_e, "rst_rot");
    for (int c = 0; c < 45; c++) begin
      pos = c % 10;
      own = (c / 10) % 4;
      g   = (pos < 8) ? 4'(1 << own) : 4'b0000;
      step(0, 1'b1, 4'b1111, mk(g, own, pos < 8, pos == 8), $sformatf("rot4_c%0d", c));
    end

    // Lone requester must never be forced off, well past hold counter saturation.
    step(0, 1'b0, 4'b0000, rst_e, "rst_hold");
    for (int c = 0; c < 300; c++)
      step(0, 1'b1, 4'b0100, mk(4'b0100, 2, 1'b1, 1'b0), $sformatf("hold_c%0d", c));
    step(0, 1'b1, 4'b0000, mk(4'b0000, 2, 1'b0, 1'b1), "hold_release");
    step(0, 1'b1, 4'b0000, mk(4'b0000, 2, 1'b0, 1'b0), "hold_idle");

    // Owner 1 drops as requester 3 rises, three turnaround cycles.
    step(1, 1'b0, 4'b0000, rst_e, "rst_t3");
    step(1, 1'b1, 4'b0010, mk(4'b0010, 1, 1'b1, 1'b0), "t3_grant1");
    step(1, 1'b1, 4'b0010, mk(4'b0010, 1, 1'b1, 1'b0), "t3_hold1");
    step(1, 1'b1, 4'b1000, mk(4'b0000, 1, 1'b0, 1'b1), "t3_release");
    step(1, 1'b1, 4'b1000, mk(4'b0000, 1, 1'b0, 1'b1), "t3_gap2");
    step(1, 1'b1, 4'b1000, mk(4'b0000, 1, 1'b0, 1'b1), "t3_gap3");
    step(1, 1'b1, 4'b1000, mk(4'b0000, 1, 1'b0, 1'b0), "t3_idle");
    step(1, 1'b1, 4'b1000, mk(4'b1000, 3, 1'b1, 1'b0), "t3_grant3");

    // Three requesters: rotation wraps modulo 3.
    step(2, 1'b0, 4'b0000, rst_e, "rst_n3");
    for (int c = 0; c < 45; c++) begin
      pos = c % 10;
      own = (c / 10) % 3;
      g   = (pos < 8) ? 4'(1 << own) : 4'b0000;
      step(2, 1'b1, 4'b0111, mk(g, own, pos < 8, pos == 8), $sformatf("rot3_c%0d", c));
      n_asrt++;
      if (sel_c == 2'd3) begin
        n_fail++;
        $display("FAIL rot3_sel_range_c%0d: got sel=%0d, required sel < 3", c, sel_c);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
